// File: rtl/reservoir_readout_pkg.sv
// rtl/reservoir_readout_pkg.sv - default sizing and readout weights for the reservoir spike readout
package reservoir_readout_pkg;

    localparam int DEF_N_NEURONS = 10;
    localparam int DEF_WIN_LEN   = 16;
    localparam int DEF_CNT_W     = 8;
    localparam int WEIGHT_W      = 16;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef weight_t weight_arr_t [DEF_N_NEURONS];

    localparam weight_arr_t DEF_WEIGHTS = '{
        16'sd3, -16'sd2, 16'sd5, -16'sd1, 16'sd4,
        16'sd0, -16'sd7, 16'sd2, 16'sd1, -16'sd3
    };

    // Neurons beyond the default table contribute nothing to the weighted sum.
    function automatic weight_t weight_of(input int idx);
        weight_t w;
        w = '0;
        for (int k = 0; k < DEF_N_NEURONS; k++) begin
            if (k == idx) begin
                w = DEF_WEIGHTS[k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spike_counter.sv
// rtl/spike_counter.sv - per-neuron saturating spike accumulator with window clear and freeze
module spike_counter
    import reservoir_readout_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    input  logic             clear,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    // count_next already includes this cycle's spike so the window-end sample is never lost.
    always_comb begin
        count_next = count;
        if (spike && (count != CNT_MAX)) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= clear ? '0 : count_next;
        end
    end

endmodule

// File: rtl/reservoir_spike_readout.sv
// rtl/reservoir_spike_readout.sv - windowed spike-count readout with valid/ready frame output
// Optional weighted_sum output enabled by READOUT_WEIGHTED_SUM_EN.
module reservoir_spike_readout
    import reservoir_readout_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int WIN_LEN   = DEF_WIN_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_NEURONS-1:0]       spikes_in,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [N_NEURONS*CNT_W-1:0] frame_counts,
    output logic [15:0]                frame_idx,
    output logic                       overrun
`ifdef READOUT_WEIGHTED_SUM_EN
    ,
    output logic signed [31:0]         weighted_sum
`endif
);

    localparam logic [15:0] WIN_LAST = 16'(WIN_LEN - 1);

    logic [15:0]                win_cnt;
    logic [15:0]                win_num;
    logic                       win_end;
    logic                       take;
    logic [N_NEURONS*CNT_W-1:0] counts_next;

    assign win_end = en && (win_cnt == WIN_LAST);
    // A finished window lands in the output register only if it is free or being drained now.
    assign take    = win_end && (!frame_valid || frame_ready);

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cnt
        spike_counter #(
            .CNT_W (CNT_W)
        ) u_spike_counter (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .spike      (spikes_in[g]),
            .clear      (win_end),
            .count_next (counts_next[g*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt      <= '0;
            win_num      <= '0;
            frame_valid  <= 1'b0;
            frame_counts <= '0;
            frame_idx    <= '0;
            overrun      <= 1'b0;
        end else begin
            if (en) begin
                win_cnt <= win_end ? '0 : win_cnt + 16'd1;
            end
            if (win_end) begin
                win_num <= win_num + 16'd1;
            end
            if (take) begin
                frame_valid  <= 1'b1;
                frame_counts <= counts_next;
                frame_idx    <= win_num;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (win_end && !take) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef READOUT_WEIGHTED_SUM_EN
    logic signed [31:0] wsum_next;

    always_comb begin
        wsum_next = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            wsum_next = wsum_next
                      + 32'(signed'({1'b0, counts_next[i*CNT_W +: CNT_W]})) * 32'(weight_of(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weighted_sum <= '0;
        end else if (take) begin
            weighted_sum <= wsum_next;
        end
    end
`endif

endmodule

// File: tb/tb_reservoir_spike_readout.sv
// tb/tb_reservoir_spike_readout.sv - self-checking bench for reservoir_spike_readout
module tb_reservoir_spike_readout;

    localparam int N  = 10;
    localparam int WL = 16;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, frame_ready, frame_valid, overrun;
    logic [9:0]  spikes_in;
    logic [79:0] frame_counts;
    logic [15:0] frame_idx;

    logic        s_rst, s_en, s_ready, s_valid, s_overrun;
    logic [9:0]  s_spikes;
    logic [79:0] s_counts;
    logic [15:0] s_idx;

`ifdef READOUT_WEIGHTED_SUM_EN
    logic signed [31:0] weighted_sum, s_weighted_sum;
`endif

    reservoir_spike_readout dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .spikes_in    (spikes_in),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_counts (frame_counts),
        .frame_idx    (frame_idx),
        .overrun      (overrun)
`ifdef READOUT_WEIGHTED_SUM_EN
        ,
        .weighted_sum (weighted_sum)
`endif
    );

    reservoir_spike_readout #(.N_NEURONS(10), .WIN_LEN(300), .CNT_W(8)) dut_sat (
        .clk          (clk),
        .rst          (s_rst),
        .en           (s_en),
        .spikes_in    (s_spikes),
        .frame_valid  (s_valid),
        .frame_ready  (s_ready),
        .frame_counts (s_counts),
        .frame_idx    (s_idx),
        .overrun      (s_overrun)
`ifdef READOUT_WEIGHTED_SUM_EN
        ,
        .weighted_sum (s_weighted_sum)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: per-window spike tallies and a one-deep frame holder.
    bit model_on = 1'b0;
    int m_pos, m_win, m_idx;
    int m_acc [N];
    int m_cnt [N];
    bit m_valid, m_ovr;

    task automatic model_reset();
        m_pos = 0; m_win = 0; m_idx = 0; m_valid = 0; m_ovr = 0;
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        bit hs, took;
        if (!rst) begin
            model_reset();
            return;
        end
        hs   = m_valid && frame_ready;
        took = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (spikes_in[i]) m_acc[i] = (m_acc[i] + 1 > CMAX) ? CMAX : m_acc[i] + 1;
            end
            if (m_pos == WL - 1) begin
                if (!m_valid || frame_ready) begin
                    m_valid = 1;
                    m_cnt   = m_acc;
                    m_idx   = m_win;
                    took    = 1;
                end else begin
                    m_ovr = 1;
                end
                for (int i = 0; i < N; i++) m_acc[i] = 0;
                m_win = (m_win + 1) % 65536;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (!took && hs) m_valid = 0;
    endtask

    task automatic model_compare();
        logic [79:0] p;
        chk("rnd_valid", 80'(frame_valid), 80'(m_valid));
        chk("rnd_overrun", 80'(overrun), 80'(m_ovr));
        if (m_valid) begin
            for (int i = 0; i < N; i++) p[i*CW +: CW] = 8'(m_cnt[i]);
            chk("rnd_counts", frame_counts, p);
            chk("rnd_idx", 80'(frame_idx), 80'(m_idx));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_step();
        #1;
        if (model_on) model_compare();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [9:0]  spikes;
        logic [79:0] exp_counts;
        logic [15:0] exp_idx;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int nv, nframes, first_t, second_t, stable;
        logic [79:0] held;

        tbl[0] = '{10'h3FF, 80'h10101010101010101010, 16'd0};
        tbl[1] = '{10'h001, 80'h00000000000000000010, 16'd1};
        tbl[2] = '{10'h2AA, 80'h10001000100010001000, 16'd2};
        tbl[3] = '{10'h000, 80'h00000000000000000000, 16'd3};

        rst = 0; en = 0; frame_ready = 0; spikes_in = '0;
        s_rst = 0; s_en = 0; s_ready = 1; s_spikes = '0;
        tick();
        tick();
        chk("reset_valid", 80'(frame_valid), 80'd0);
        chk("reset_overrun", 80'(overrun), 80'd0);
        chk("reset_counts", frame_counts, 80'd0);
        chk("reset_idx", 80'(frame_idx), 80'd0);

        // Full windows with constant patterns, consumer always ready.
        rst = 1; en = 1; frame_ready = 1;
        for (int k = 0; k < 4; k++) begin
            spikes_in = tbl[k].spikes;
            nv = 0;
            for (int t = 0; t < WL; t++) begin
                tick();
                if (frame_valid) nv++;
            end
            chk("tbl_counts", frame_counts, tbl[k].exp_counts);
            chk("tbl_idx", 80'(frame_idx), 80'(tbl[k].exp_idx));
            chk("tbl_valid_once", 80'(nv), 80'd1);
        end

        // Consumer stalls for two windows: frame 0 held, frame 1 dropped.
        do_reset();
        frame_ready = 0; spikes_in = 10'h3FF;
        repeat (WL) tick();
        chk("hold_valid", 80'(frame_valid), 80'd1);
        chk("hold_counts", frame_counts, 80'h10101010101010101010);
        chk("hold_overrun_pre", 80'(overrun), 80'd0);
        held = frame_counts;
        spikes_in = 10'h001;
        stable = 1;
        for (int t = 0; t < WL; t++) begin
            tick();
            if (frame_counts !== held || frame_idx !== 16'd0 || frame_valid !== 1'b1) stable = 0;
        end
        chk("hold_stable", 80'(stable), 80'd1);
        chk("drop_overrun", 80'(overrun), 80'd1);
        frame_ready = 1; spikes_in = 10'h004;
        tick();
        chk("drain_valid_low", 80'(frame_valid), 80'd0);
        repeat (WL - 1) tick();
        chk("after_drop_valid", 80'(frame_valid), 80'd1);
        chk("after_drop_idx", 80'(frame_idx), 80'd2);
        chk("after_drop_counts", frame_counts, 80'h00000000000000100000);
        chk("overrun_sticky", 80'(overrun), 80'd1);

        // Reset at sample 7 of a window discards partial counts and the held frame.
        frame_ready = 0; spikes_in = 10'h3FF;
        repeat (7) tick();
        rst = 0;
        tick();
        chk("midrst_valid", 80'(frame_valid), 80'd0);
        chk("midrst_overrun", 80'(overrun), 80'd0);
        chk("midrst_counts", frame_counts, 80'd0);
        chk("midrst_idx", 80'(frame_idx), 80'd0);
        rst = 1; spikes_in = 10'h008; frame_ready = 1;
        repeat (WL) tick();
        chk("postrst_counts", frame_counts, 80'h00000000000010000000);
        chk("postrst_idx", 80'(frame_idx), 80'd0);
        chk("postrst_valid", 80'(frame_valid), 80'd1);

        // en alternating 1,0: one frame per 32 cycles.
        do_reset();
        frame_ready = 1; spikes_in = 10'h001;
        nframes = 0; first_t = 0; second_t = 0;
        for (int t = 1; t <= 64; t++) begin
            en = (t % 2 == 1);
            tick();
            if (frame_valid) begin
                nframes++;
                if (nframes == 1) first_t = t;
                if (nframes == 2) second_t = t;
                chk("toggle_counts", frame_counts, 80'h00000000000000000010);
            end
        end
        chk("toggle_nframes", 80'(nframes), 80'd2);
        chk("toggle_first", 80'(first_t), 80'd31);
        chk("toggle_period", 80'(second_t - first_t), 80'd32);

`ifdef READOUT_WEIGHTED_SUM_EN
        do_reset();
        en = 1; frame_ready = 1; spikes_in = 10'h003;
        repeat (WL) tick();
        chk("wsum_valid", 80'(frame_valid), 80'd1);
        chk("wsum_value", 80'(weighted_sum), 80'(32'sd16));
`endif

        // Saturation with a 300-sample window.
        en = 0;
        s_rst = 1; s_en = 1; s_ready = 1; s_spikes = 10'h008;
        nv = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (s_valid) nv++;
        end
        chk("sat_valid_once", 80'(nv), 80'd1);
        chk("sat_valid", 80'(s_valid), 80'd1);
        chk("sat_counts", s_counts, 80'h000000000000FF000000);
        chk("sat_idx", 80'(s_idx), 80'd0);
        s_en = 0;

        // Randomized traffic against the reference model.
        rst = 0; en = 0; frame_ready = 0;
        model_on = 1;
        tick();
        rst = 1;
        for (int t = 0; t < 3000; t++) begin
            en          = ($urandom_range(0, 9) < 7);
            spikes_in   = 10'($urandom);
            frame_ready = ($urandom_range(0, 9) < 3);
            rst         = ($urandom_range(0, 999) != 0);
            tick();
        end
        model_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservoir_spike_readout.md
RESERVOIR_SPIKE_READOUT -- requirements
Module: reservoir_spike_readout

Interface
REQ-001 Parameter N_NEURONS, default 10, number of reservoir neurons (spike lines).
REQ-002 Parameter WIN_LEN, default 16, samples per counting window (range 2..65535).
REQ-003 Parameter CNT_W, default 8, width of each per-neuron spike count.
REQ-004 Port clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-low reset.
REQ-006 Port en  in  1  sample-enable; spikes sampled and window advanced only when high.
REQ-007 Port spikes_in  in  N_NEURONS  one spike bit per neuron (i_out of each LIF neuron).
REQ-008 Port frame_valid  out  1  completed count frame available.
REQ-009 Port frame_ready  in  1  consumer accepts frame when high with frame_valid.
REQ-010 Port frame_counts  out  N_NEURONS*CNT_W  packed counts, neuron 0 in LSBs.
REQ-011 Port frame_idx  out  16  window number of the presented frame.
REQ-012 Port overrun  out  1  sticky flag: a completed window was dropped.

Function
REQ-013 Window counter shall count 0..WIN_LEN-1 on each en-high cycle, wrapping to 0 after WIN_LEN-1.
REQ-014 Each en-high cycle, count[i] shall increment by spikes_in[i], saturating at 2^CNT_W-1.
REQ-015 en low shall freeze window counter and all accumulators.
REQ-016 On the en-high cycle with window counter = WIN_LEN-1, that cycle's spikes shall be included, the final counts transferred to the output register, and accumulators cleared to 0 for the next window (no lost sample).
REQ-017 frame_valid shall assert the cycle after the window-end sample (latency 1).
REQ-018 Transfer shall occur if output register is empty or is being consumed (frame_valid and frame_ready) in the same cycle.
REQ-019 Otherwise the new frame shall be dropped, overrun set, accumulators still cleared; the held frame stays unchanged.
REQ-020 frame_counts and frame_idx shall be stable while frame_valid is high and frame_ready low.
REQ-021 frame_valid shall deassert the cycle after a handshake unless a new transfer occurs in that same cycle.
REQ-022 Window number shall increment per completed window including dropped ones (gaps reveal drops), wrapping 0xFFFF to 0.
REQ-023 overrun shall clear only on reset.

Reset
REQ-024 While rst low: window counter, accumulators, frame_counts, frame_idx, window number = 0; frame_valid = 0; overrun = 0.
REQ-025 Reset asserted mid-window or mid-handshake shall discard partial counts and any pending frame immediately.

Configuration
REQ-026 With READOUT_WEIGHTED_SUM_EN defined: extra port weighted_sum out 32 signed, = sum of count[i]*W[i] (signed 16-bit weights from package), registered with the frame, same valid/stability rules, reset 0.
REQ-027 Without READOUT_WEIGHTED_SUM_EN: no weighted_sum port and no multiply logic.

Structure
REQ-028 Package reservoir_readout_pkg shall hold default N_NEURONS, WIN_LEN, CNT_W, weight array type and default readout weights.
REQ-029 Sub-module spike_counter (one per neuron: saturating increment, clear, freeze) shall be instantiated via generate.

Verification
REQ-030 en=1, spikes_in=10'h3FF every cycle, frame_ready=1, WIN_LEN=16 -> each frame all counts 16, frame_idx 0,1,2..., frame_valid one cycle per 16.
REQ-031 neuron 3 spikes every cycle, WIN_LEN=300, CNT_W=8 -> count[3]=255 (saturated), others 0.
REQ-032 frame_ready=0 for 2 full windows -> first frame held stable, overrun=1, next accepted frame has frame_idx=2 (idx 1 dropped).
REQ-033 en toggled 1,0 alternately with spikes_in[0]=1 always -> frame every 32 cycles, count[0]=16.
REQ-034 rst low at sample 7 of window, then released -> all outputs 0, next frame counts only post-reset samples, frame_idx=0.
REQ-035 READOUT_WEIGHTED_SUM_EN, W[0]=3, W[1]=-2, counts 16/16, others 0 -> weighted_sum=16.
